// File: rtl/fp16_add_seq_pkg.sv
// rtl/fp16_add_seq_pkg.sv - shared FSM states and FP16 constants for the sequential adder
package fp16_add_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  localparam logic [4:0]  EXP_MAX     = 5'b11111;
  localparam logic [15:0] QNAN_CANCEL = 16'h7FFF;
  localparam int          BIAS        = 15;
  localparam int          SIG_W       = 14;

endpackage

// File: rtl/fp16_special_check.sv
// rtl/fp16_special_check.sv - NaN/inf/zero operand classification and result selection
module fp16_special_check
  import fp16_add_seq_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        hit
);

  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic [9:0] min_mant;

  assign a_nan  = (a[14:10] == EXP_MAX) && (a[9:0] != 10'd0);
  assign b_nan  = (b[14:10] == EXP_MAX) && (b[9:0] != 10'd0);
  assign a_inf  = (a[14:10] == EXP_MAX) && (a[9:0] == 10'd0);
  assign b_inf  = (b[14:10] == EXP_MAX) && (b[9:0] == 10'd0);
  assign a_zero = (a[14:0] == 15'd0);
  assign b_zero = (b[14:0] == 15'd0);
  assign min_mant = (a[9:0] < b[9:0]) ? a[9:0] : b[9:0];

  // Priority order matters: a NaN beats an inf, an inf beats a zero
  always_comb begin
    result = 16'h0000;
    hit    = 1'b1;
    if (a_nan && b_nan)      result = {a[15], EXP_MAX, min_mant};
    else if (a_nan)          result = a;
    else if (b_nan)          result = b;
    else if (a_inf && b_inf) result = (a[15] == b[15]) ? a : QNAN_CANCEL;
    else if (a_inf)          result = a;
    else if (b_inf)          result = b;
    else if (a_zero)         result = b;
    else if (b_zero)         result = a;
    else                     hit    = 1'b0;
  end

endmodule

// File: rtl/fp16_add_seq.sv
// rtl/fp16_add_seq.sv - multi-cycle FP16 adder: check, align, add, normalise, round
module fp16_add_seq
  import fp16_add_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        done,
  output logic        busy,
  output logic        exc_flag
);

  state_t             state;
  logic [15:0]        a_r, b_r;
  logic               sign_r, sub_r, zero_r;
  logic [5:0]         exp_r;
  logic [SIG_W-1:0]   sig_r, sig_small;

  logic [15:0]        spec_result;
  logic               spec_hit;

  fp16_special_check u_special (
    .a      (a_r),
    .b      (b_r),
    .result (spec_result),
    .hit    (spec_hit)
  );

  // Subnormals behave as exponent 1 with a cleared hidden bit
  logic [4:0]       a_exp, b_exp, big_exp, small_exp, diff;
  logic [SIG_W-1:0] a_sig, b_sig, big_sig, small_sig, shifted, lost;
  logic             a_ge;

  assign a_exp     = (a_r[14:10] == 5'd0) ? 5'd1 : a_r[14:10];
  assign b_exp     = (b_r[14:10] == 5'd0) ? 5'd1 : b_r[14:10];
  assign a_sig     = {(a_r[14:10] != 5'd0), a_r[9:0], 3'b000};
  assign b_sig     = {(b_r[14:10] != 5'd0), b_r[9:0], 3'b000};
  assign a_ge      = (a_r[14:0] >= b_r[14:0]);
  assign big_exp   = a_ge ? a_exp : b_exp;
  assign small_exp = a_ge ? b_exp : a_exp;
  assign big_sig   = a_ge ? a_sig : b_sig;
  assign small_sig = a_ge ? b_sig : a_sig;
  assign diff      = big_exp - small_exp;

  always_comb begin
    lost    = '0;
    shifted = '0;
    if (diff >= 5'd14) begin
      shifted = {{(SIG_W-1){1'b0}}, |small_sig};
    end else begin
      lost       = small_sig & ~({SIG_W{1'b1}} << diff);
      shifted    = small_sig >> diff;
      shifted[0] = shifted[0] | (|lost);
    end
  end

  logic [SIG_W:0] sum;
  assign sum = sub_r ? ({1'b0, sig_r} - {1'b0, sig_small})
                     : ({1'b0, sig_r} + {1'b0, sig_small});

  // Round-to-nearest-even on guard/round/sticky; sig_r[3] is the result LSB
  logic        round_up, rnd_hid;
  logic [11:0] rnd;
  logic [5:0]  rnd_exp;
  logic [9:0]  rnd_man;
  logic [15:0] packed_res;

  assign round_up = sig_r[2] & (sig_r[1] | sig_r[0] | sig_r[3]);
  assign rnd      = {1'b0, sig_r[13:3]} + {11'd0, round_up};

  always_comb begin
    rnd_exp = exp_r;
    rnd_man = rnd[9:0];
    rnd_hid = rnd[10];
    if (rnd[11]) begin
      rnd_exp = exp_r + 6'd1;
      rnd_man = 10'd0;
      rnd_hid = 1'b1;
    end
    if (zero_r)
      packed_res = 16'h0000;
    else if (rnd_exp >= 6'd31)
      packed_res = {sign_r, EXP_MAX, 10'd0};
    else
      packed_res = {sign_r, (rnd_hid ? rnd_exp[4:0] : 5'd0), rnd_man};
  end

  assign done = (state == S_DONE);
  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      a_r       <= '0;
      b_r       <= '0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      zero_r    <= 1'b0;
      exp_r     <= '0;
      sig_r     <= '0;
      sig_small <= '0;
      result    <= 16'h0000;
      exc_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (spec_hit) begin
            result   <= spec_result;
            exc_flag <= 1'b1;
            state    <= S_DONE;
          end else begin
            state <= S_ALIGN;
          end
        end
        S_ALIGN: begin
          sign_r    <= a_ge ? a_r[15] : b_r[15];
          sub_r     <= a_r[15] ^ b_r[15];
          exp_r     <= {1'b0, big_exp};
          sig_r     <= big_sig;
          sig_small <= shifted;
          state     <= S_ADD;
        end
        S_ADD: begin
          zero_r <= (sum == '0);
          if (sum[SIG_W]) begin
            sig_r <= {sum[SIG_W:2], sum[1] | sum[0]};
            exp_r <= exp_r + 6'd1;
          end else begin
            sig_r <= sum[SIG_W-1:0];
          end
          state <= S_NORM;
        end
        S_NORM: begin
          if (!zero_r && !sig_r[SIG_W-1] && exp_r > 6'd1) begin
            sig_r <= sig_r << 1;
            exp_r <= exp_r - 6'd1;
          end else begin
            state <= S_ROUND;
          end
        end
        S_ROUND: begin
          result   <= packed_res;
          exc_flag <= 1'b0;
          state    <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_seq.sv
// tb/tb_fp16_add_seq.sv - directed bench with a value-level FP16 addition model
module tb_fp16_add_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = 16'h0, b = 16'h0;
  logic [15:0] result;
  logic        done, busy, exc_flag;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_res = 16'h0;
  logic        exp_exc = 1'b0;
  logic        expect_done = 1'b0;

  fp16_add_seq dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .result   (result),
    .done     (done),
    .busy     (busy),
    .exc_flag (exc_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s vec%0d actual=%h required=%h", name, id, act, req);
    end
  endtask

  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] != 0);
  endfunction
  function automatic bit is_inf(input logic [15:0] x);
    return (x[14:10] == 5'h1f) && (x[9:0] == 0);
  endfunction
  function automatic bit is_zero(input logic [15:0] x);
    return x[14:0] == 0;
  endfunction

  function automatic bit model_special(input logic [15:0] x, input logic [15:0] y);
    return is_nan(x) || is_nan(y) || is_inf(x) || is_inf(y) || is_zero(x) || is_zero(y);
  endfunction

  // Magnitude in units of 2^-24 (the smallest subnormal)
  function automatic longint magnitude(input logic [15:0] x);
    longint m;
    m = longint'(x[9:0]);
    if (x[14:10] == 0) return m;
    return (m + 1024) <<< (int'(x[14:10]) - 1);
  endfunction

  function automatic logic [15:0] model_add(input logic [15:0] x, input logic [15:0] y);
    longint s, m, q, rem, half;
    int p, sh, e;
    logic [15:0] r;
    if (is_nan(x) && is_nan(y)) return {x[15], 5'h1f, (x[9:0] < y[9:0]) ? x[9:0] : y[9:0]};
    if (is_nan(x)) return x;
    if (is_nan(y)) return y;
    if (is_inf(x) && is_inf(y)) return (x[15] == y[15]) ? x : 16'h7FFF;
    if (is_inf(x)) return x;
    if (is_inf(y)) return y;
    if (is_zero(x)) return y;
    if (is_zero(y)) return x;
    s = (x[15] ? -magnitude(x) : magnitude(x)) + (y[15] ? -magnitude(y) : magnitude(y));
    if (s == 0) return 16'h0000;
    r[15] = (s < 0);
    m = (s < 0) ? -s : s;
    if (m < 2048) begin
      r[14:0] = 15'(m);
      return r;
    end
    p = 0;
    for (int i = 0; i < 62; i++) if ((m >>> i) != 0) p = i;
    sh   = p - 10;
    q    = m >>> sh;
    rem  = m - (q <<< sh);
    half = longint'(1) <<< (sh - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q == 2048) begin
      q  = 1024;
      sh = sh + 1;
    end
    e = sh + 1;
    if (e >= 31) return {r[15], 5'h1f, 10'h0};
    r[14:10] = 5'(e);
    r[9:0]   = q[9:0];
    return r;
  endfunction

  always @(negedge clk) begin
    if (done) begin
      if (!expect_done) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done actual=1 required=0");
      end else begin
        check("result", 0, {16'h0, result}, {16'h0, exp_res});
        check("exc_flag", 0, {31'h0, exc_flag}, {31'h0, exp_exc});
      end
    end
  end

  task automatic run_op(input int id, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] lit_res, input bit lit_exc, input int lit_lat, input bit noise);
    int n;
    bit seen;
    check("model_res", id, {16'h0, model_add(x, y)}, {16'h0, lit_res});
    check("model_exc", id, {31'h0, model_special(x, y)}, {31'h0, lit_exc});
    exp_res = model_add(x, y);
    exp_exc = model_special(x, y);
    @(negedge clk);
    a = x; b = y; start = 1'b1; expect_done = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; seen = 0;
    while (n < 40 && !seen) begin
      @(posedge clk);
      n++;
      #1;
      if (done) seen = 1;
      else if (noise && n >= 2 && n < 5) begin
        a = 16'h7C00; b = 16'h7C00; start = 1'b1;
      end else start = 1'b0;
    end
    start = 1'b0;
    check("done_seen", id, {31'h0, seen}, 32'h1);
    if (seen) check("latency", id, n, lit_lat);
    @(posedge clk);
    #1;
    check("done_pulse", id, {31'h0, done}, 32'h0);
    check("idle_busy", id, {31'h0, busy}, 32'h0);
  endtask

  initial begin
    int pulses;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", 0, {16'h0, result}, 32'h0);
    check("rst_outs", 0, {29'h0, done, busy, exc_flag}, 32'h0);
    @(negedge clk) rst = 1'b0;

    run_op(1,  16'h3C00, 16'h3C00, 16'h4000, 0, 5,  0);
    run_op(2,  16'h3C00, 16'hBBFF, 16'h1000, 0, 16, 1);
    run_op(3,  16'h7C00, 16'hFC00, 16'h7FFF, 1, 1,  0);
    run_op(4,  16'h3C00, 16'h1000, 16'h3C00, 0, 5,  0);
    run_op(5,  16'h3C00, 16'h1400, 16'h3C01, 0, 5,  0);
    run_op(6,  16'h7BFF, 16'h7BFF, 16'h7C00, 0, 5,  0);
    run_op(7,  16'h3C00, 16'hBC00, 16'h0000, 0, 5,  0);
    run_op(8,  16'h0000, 16'h8000, 16'h8000, 1, 1,  0);
    run_op(9,  16'h0001, 16'h0001, 16'h0002, 0, 5,  0);
    run_op(10, 16'h4000, 16'hBC00, 16'h3C00, 0, 6,  0);
    run_op(11, 16'h3C00, 16'h0001, 16'h3C00, 0, 5,  0);
    run_op(12, 16'hFC00, 16'h3C00, 16'hFC00, 1, 1,  0);
    run_op(13, 16'h3C00, 16'h7C01, 16'h7C01, 1, 1,  0);
    run_op(14, 16'h7E00, 16'h7D00, 16'h7D00, 1, 1,  0);

    // Abort a long operation while it is normalising
    expect_done = 1'b0;
    @(negedge clk);
    a = 16'h3C00; b = 16'hBBFF; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("abort_result", 15, {16'h0, result}, 32'h0);
    check("abort_outs", 15, {29'h0, done, busy, exc_flag}, 32'h0);
    @(negedge clk) rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1 if (done) pulses++;
    end
    check("abort_no_done", 15, pulses, 0);

    run_op(16, 16'h3C00, 16'h3C00, 16'h4000, 0, 5, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
